// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the DSP48A1 MAC sequencer: OPMODE tags,
// sequencer states and the slice's fixed accept-to-result latency.
package dsp48a1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    localparam logic [7:0] OPM_RST   = 8'h00;
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_NEXT  = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;

    localparam int DSP_LAT = 4;

endpackage

// File: rtl/dsp_tag_pipe.sv
// Two-stage delay line that lines a pair's OPMODE tag up with its
// product in the slice M register.
module dsp_tag_pipe
    import dsp48a1_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tag,
    output logic [7:0] o_opmode
);

    logic [7:0] r_tag1;
    logic [7:0] r_tag2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag1 <= OPM_RST;
            r_tag2 <= OPM_RST;
        end else begin
            r_tag1 <= i_tag;
            r_tag2 <= r_tag1;
        end
    end

    assign o_opmode = r_tag2;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Feeds operand pairs into a DSP48A1 slice so P accumulates their dot
// product, then captures P and offers it through a valid/ready port.
module dsp_mac_sequencer
    import dsp48a1_pkg::*;
#(
    parameter  int MAX_LEN = 256,
    parameter  int LAT     = DSP_LAT,
    localparam int TW      = $clog2(MAX_LEN + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [17:0]   in_a,
    input  logic [17:0]   in_b,
    input  logic          in_last,
    output logic [17:0]   dsp_a,
    output logic [17:0]   dsp_b,
    output logic [7:0]    dsp_opmode,
    input  logic [47:0]   dsp_p,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [47:0]   res_data,
    output logic [TW-1:0] res_taps,
    output logic          res_trunc
);

    localparam int DW = $clog2(LAT) + 1;

    state_t        r_state;
    state_t        w_next;
    logic [17:0]   r_a;
    logic [17:0]   r_b;
    logic [TW-1:0] r_taps;
    logic [DW-1:0] r_drain;
    logic          r_valid;
    logic [47:0]   r_data;
    logic          r_trunc;

    logic          w_accept;
    logic          w_full;
    logic          w_drain_done;
    logic [TW-1:0] w_taps_nxt;
    logic [7:0]    w_tag;

    assign in_ready     = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
    assign w_accept     = in_valid && in_ready;
    assign w_taps_nxt   = (r_state == ST_IDLE) ? TW'(1) : r_taps + TW'(1);
    assign w_full       = (w_taps_nxt == TW'(MAX_LEN));
    assign w_drain_done = (r_drain == DW'(LAT - 1));

    always_comb begin
        w_next = r_state;
        w_tag  = OPM_HOLD;
        unique case (r_state)
            ST_IDLE, ST_ACCUM: begin
                if (w_accept) begin
                    w_tag  = (r_state == ST_IDLE) ? OPM_FIRST : OPM_NEXT;
                    w_next = (in_last || w_full) ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done)
                    w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operands are zeroed on idle edges so a bubble contributes M = 0
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_taps  <= '0;
            r_drain <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_next;
            r_a     <= w_accept ? in_a : '0;
            r_b     <= w_accept ? in_b : '0;
            if (w_accept) begin
                r_taps  <= w_taps_nxt;
                r_drain <= '0;
                if (w_full && !in_last)
                    r_trunc <= 1'b1;
            end
            if (r_state == ST_DRAIN) begin
                r_drain <= r_drain + DW'(1);
                if (w_drain_done) begin
                    r_data  <= dsp_p;
                    r_valid <= 1'b1;
                end
            end
            if ((r_state == ST_HOLD) && res_ready) begin
                r_valid <= 1'b0;
                r_trunc <= 1'b0;
            end
        end
    end

    dsp_tag_pipe u_tag_pipe (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_tag    (w_tag),
        .o_opmode (dsp_opmode)
    );

    assign dsp_a     = r_a;
    assign dsp_b     = r_b;
    assign res_valid = r_valid;
    assign res_data  = r_data;
    assign res_taps  = r_taps;
    assign res_trunc = r_trunc;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice,
// checked against a dot-product reference and literal results.
module tb_dsp_mac_sequencer;

    localparam int ML = 4;
    localparam int LT = 4;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [17:0] in_a = '0;
    logic signed [17:0] in_b = '0;
    logic               in_last = 1'b0;
    logic [17:0]        dsp_a;
    logic [17:0]        dsp_b;
    logic [7:0]         dsp_opmode;
    logic [47:0]        dsp_p;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [47:0]        res_data;
    logic [2:0]         res_taps;
    logic               res_trunc;

    int n_chk = 0;
    int n_fail = 0;

    dsp_mac_sequencer #(.MAX_LEN(ML), .LAT(LT)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_p      (dsp_p),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_taps   (res_taps),
        .res_trunc  (res_trunc)
    );

    always #5 CLK = ~CLK;

    // Slice model: A1/B1 -> M -> P, OPMODE register aligned with M
    logic signed [17:0] s_a1 = '0;
    logic signed [17:0] s_b1 = '0;
    logic signed [35:0] s_m = '0;
    logic [7:0]         s_opm = '0;
    logic [47:0]        s_p = '0;

    always @(posedge CLK) begin
        s_a1  <= dsp_a;
        s_b1  <= dsp_b;
        s_m   <= s_a1 * s_b1;
        s_opm <= dsp_opmode;
        s_p   <= ((s_opm[3:2] == 2'b10) ? s_p : 48'd0)
               + ((s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0);
    end
    assign dsp_p = s_p;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: pair-level bookkeeping of the dot product
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_trunc = 1'b0;
    logic        m_open = 1'b0;
    int          m_left = 0;
    int          m_cnt = 0;
    logic [47:0] m_sum = '0;
    logic [47:0] m_res = '0;
    logic [17:0] m_a = '0;
    logic [17:0] m_b = '0;
    logic [7:0]  m_t1 = '0;
    logic [7:0]  m_opm = '0;

    initial begin
        logic       acc;
        logic [7:0] tag;
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                m_busy = 0; m_valid = 0; m_trunc = 0; m_open = 0;
                m_left = 0; m_cnt = 0; m_sum = '0; m_res = '0;
                m_a = '0; m_b = '0; m_t1 = '0; m_opm = '0;
            end else begin
                acc   = in_valid && !m_busy;
                tag   = !acc ? 8'h08 : (m_open ? 8'h09 : 8'h01);
                m_opm = m_t1;
                m_t1  = tag;
                m_a   = acc ? in_a : '0;
                m_b   = acc ? in_b : '0;
                if (m_valid && res_ready) begin
                    m_valid = 0; m_trunc = 0; m_busy = 0;
                end else if (m_busy && !m_valid) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_valid = 1;
                        m_res   = m_sum;
                    end
                end
                if (acc) begin
                    if (!m_open) begin
                        m_sum = '0;
                        m_cnt = 0;
                    end
                    m_sum = m_sum + 48'(longint'(in_a) * longint'(in_b));
                    m_cnt++;
                    m_open = 1;
                    if (in_last || m_cnt == ML) begin
                        m_busy  = 1;
                        m_left  = LT;
                        m_trunc = !in_last;
                        m_open  = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            chk("in_ready", in_ready, !m_busy);
            chk("res_valid", res_valid, m_valid);
            chk("dsp_a", dsp_a, m_a);
            chk("dsp_b", dsp_b, m_b);
            chk("dsp_opmode", dsp_opmode, m_opm);
            chk("res_trunc", res_trunc, m_trunc);
            if (m_valid) begin
                chk("res_data", res_data, m_res);
                chk("res_taps", res_taps, 64'(m_cnt));
            end
        end
    end

    task automatic send(input logic signed [17:0] a,
                        input logic signed [17:0] b, input logic last);
        int w;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        w = 0;
        while (1) begin
            @(negedge CLK);
            if (in_ready) break;
            w++;
            if (w > 64) begin
                chk("in_ready_wait", in_ready, 1);
                break;
            end
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res(output int edges);
        edges = 0;
        while (!res_valid && edges < 40) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        if (!res_valid)
            chk("res_valid_wait", res_valid, 1);
    endtask

    task automatic take();
        res_ready = 1'b1;
        @(posedge CLK);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dsp_a"}, dsp_a, 0);
        chk({tag, "_dsp_b"}, dsp_b, 0);
        chk({tag, "_opmode"}, dsp_opmode, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_taps"}, res_taps, 0);
        chk({tag, "_res_trunc"}, res_trunc, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        #2 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_vals("por");
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        send(2, 3, 0);
        send(4, 5, 0);
        send(-1, 7, 1);
        wait_res(e);
        chk("t1_latency", e, 4);
        chk("t1_data", res_data, 19);
        chk("t1_taps", res_taps, 3);
        chk("t1_trunc", res_trunc, 0);
        take();

        send(2, 3, 0);
        @(posedge CLK);
        #1;
        chk("gap_a0", dsp_a, 0);
        chk("gap_b0", dsp_b, 0);
        @(posedge CLK);
        #1;
        chk("gap_opmode", dsp_opmode, 8'h08);
        chk("gap_a1", dsp_a, 0);
        chk("gap_b1", dsp_b, 0);
        send(4, 5, 0);
        send(-1, 7, 1);
        wait_res(e);
        chk("t2_data", res_data, 19);
        take();

        send(-131072, -131072, 1);
        wait_res(e);
        chk("t3_data", res_data, 48'h0004_0000_0000);
        chk("t3_taps", res_taps, 1);
        take();

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(1, 1, i == 5);
            end
            begin
                int e2;
                wait_res(e2);
                chk("t4a_data", res_data, 4);
                chk("t4a_trunc", res_trunc, 1);
                chk("t4a_taps", res_taps, 4);
                take();
                wait_res(e2);
                chk("t4b_data", res_data, 2);
                chk("t4b_trunc", res_trunc, 0);
                chk("t4b_taps", res_taps, 2);
                take();
            end
        join

        send(1, 2, 1);
        wait_res(e);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 2);
            chk("hold_in_ready", in_ready, 0);
        end
        take();
        chk("after_take_in_ready", in_ready, 1);
        send(5, 5, 1);
        wait_res(e);
        chk("t5_data", res_data, 25);
        take();

        send(7, 7, 0);
        send(2, 2, 0);
        RST = 1'b1;
        #1;
        chk_reset_vals("mid");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        send(3, 3, 1);
        wait_res(e);
        chk("t6_data", res_data, 9);
        chk("t6_taps", res_taps, 1);
        take();

        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
